// File: rtl/nlc_pkg.sv
// Shared types and defaults for the nested loop counter.
package nlc_pkg;

    localparam int NLC_BITWIDTH_DEF = 10;
    localparam int NLC_LEVELS_DEF   = 3;

    typedef enum logic [1:0] {
        NLC_IDLE = 2'd0,
        NLC_RUN  = 2'd1,
        NLC_DONE = 2'd2
    } nlc_state_e;

endpackage

// File: rtl/nlc_level.sv
// One digit of the nested counter: index register, latched limit and stride, carry chain.
// Terminal when index + step exceeds the limit; a terminal digit wraps to 0 when carried into.
module nlc_level #(
    parameter int BW = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic          carry_i,
    input  logic [BW-1:0] limit_i,
    input  logic [BW-1:0] stride_i,
    output logic [BW-1:0] idx_o,
    output logic          terminal_o,
    output logic          carry_o,
    output logic          eqn_o
);

    logic [BW-1:0] idx_q, idx_d;
    logic [BW-1:0] lim_q, lim_d;
    logic [BW-1:0] stride_q, stride_d;
    logic [BW-1:0] step;
    logic [BW:0]   sum;

    // A zero stride would never advance, so it steps by one instead.
    assign step       = (stride_q == '0) ? {{(BW-1){1'b0}}, 1'b1} : stride_q;
    assign sum        = {1'b0, idx_q} + {1'b0, step};
    assign terminal_o = (sum > {1'b0, lim_q});
    assign carry_o    = carry_i & terminal_o;
    assign eqn_o      = (idx_q == lim_q);
    assign idx_o      = idx_q;

    always_comb begin
        idx_d    = idx_q;
        lim_d    = lim_q;
        stride_d = stride_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (load_i) begin
            idx_d    = '0;
            lim_d    = limit_i;
            stride_d = stride_i;
        end else if (carry_i) begin
            idx_d = terminal_o ? '0 : sum[BW-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q    <= '0;
            lim_q    <= '0;
            stride_q <= '0;
        end else begin
            idx_q    <= idx_d;
            lim_q    <= lim_d;
            stride_q <= stride_d;
        end
    end

endmodule

// File: rtl/nested_loop_counter.sv
// Multi-level nested loop counter with FSM, Done pulse and selectable active clock edge.
// Optional per-level stride input enabled by macro NLC_STRIDE_EN.
module nested_loop_counter
    import nlc_pkg::*;
#(
    parameter int BITWIDTH = NLC_BITWIDTH_DEF,
    parameter int LEVELS   = NLC_LEVELS_DEF,
    parameter int NEG_EDGE = 1
) (
    input  logic                       NLC_Clk,
    input  logic                       NLC_Rst,
    input  logic                       NLC_Clr,
    input  logic                       NLC_Start,
    input  logic                       NLC_En,
    input  logic [LEVELS*BITWIDTH-1:0] NLC_Limit,
`ifdef NLC_STRIDE_EN
    input  logic [LEVELS*BITWIDTH-1:0] NLC_Stride,
`endif
    output logic [LEVELS*BITWIDTH-1:0] NLC_Out,
    output logic [LEVELS-1:0]          NLC_Eqn_Flag,
    output logic [LEVELS-1:0]          NLC_Wrap,
    output logic                       NLC_Busy,
    output logic                       NLC_Done
);

    logic core_clk;

    generate
        if (NEG_EDGE != 0) begin : g_neg_edge
            assign core_clk = ~NLC_Clk;
        end else begin : g_pos_edge
            assign core_clk = NLC_Clk;
        end
    endgenerate

    logic [LEVELS*BITWIDTH-1:0] stride_in;
`ifdef NLC_STRIDE_EN
    assign stride_in = NLC_Stride;
`else
    assign stride_in = {LEVELS{{{(BITWIDTH-1){1'b0}}, 1'b1}}};
`endif

    nlc_state_e state_q, state_d;
    logic       done_q, done_d;
    logic       load, adv, active;
    logic [LEVELS-1:0] terminal, carry, eqn, term_pre;

    assign active = (state_q != NLC_IDLE);

    genvar k;
    generate
        for (k = 0; k < LEVELS; k++) begin : g_level
            logic carry_in;
            if (k == 0) begin : g_first
                assign carry_in    = adv;
                assign term_pre[k] = terminal[k];
            end else begin : g_rest
                assign carry_in    = carry[k-1];
                assign term_pre[k] = term_pre[k-1] & terminal[k];
            end

            nlc_level #(
                .BW (BITWIDTH)
            ) u_level (
                .clk_i      (core_clk),
                .rst_i      (NLC_Rst),
                .clr_i      (NLC_Clr),
                .load_i     (load),
                .carry_i    (carry_in),
                .limit_i    (NLC_Limit[k*BITWIDTH +: BITWIDTH]),
                .stride_i   (stride_in[k*BITWIDTH +: BITWIDTH]),
                .idx_o      (NLC_Out[k*BITWIDTH +: BITWIDTH]),
                .terminal_o (terminal[k]),
                .carry_o    (carry[k]),
                .eqn_o      (eqn[k])
            );
        end
    endgenerate

    assign NLC_Eqn_Flag = active ? eqn : '0;
    assign NLC_Wrap     = active ? term_pre : '0;
    assign NLC_Busy     = (state_q == NLC_RUN);
    assign NLC_Done     = done_q;

    // The final step is taken from the terminal flags directly so Done does not wait on the ripple chain.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        load    = 1'b0;
        adv     = 1'b0;
        if (NLC_Clr) begin
            state_d = NLC_IDLE;
        end else begin
            case (state_q)
                NLC_IDLE: begin
                    if (NLC_Start) begin
                        load    = 1'b1;
                        state_d = NLC_RUN;
                    end
                end
                NLC_RUN: begin
                    if (NLC_En) begin
                        adv = 1'b1;
                        if (&terminal) begin
                            done_d  = 1'b1;
                            state_d = NLC_DONE;
                        end
                    end
                end
                NLC_DONE: state_d = NLC_IDLE;
                default:  state_d = NLC_IDLE;
            endcase
        end
    end

    always_ff @(posedge core_clk or posedge NLC_Rst) begin
        if (NLC_Rst) begin
            state_q <= NLC_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_nested_loop_counter.sv
// Directed bench for nested_loop_counter with a cycle model feeding an expected-value queue.
module tb_nested_loop_counter;

    localparam int BW = 10;
    localparam int LV = 3;

    logic               NLC_Clk = 1'b0;
    logic               NLC_Rst, NLC_Clr, NLC_Start, NLC_En;
    logic [LV*BW-1:0]   NLC_Limit;
`ifdef NLC_STRIDE_EN
    logic [LV*BW-1:0]   NLC_Stride;
`endif
    logic [LV*BW-1:0]   NLC_Out;
    logic [LV-1:0]      NLC_Eqn_Flag, NLC_Wrap;
    logic               NLC_Busy, NLC_Done;

    always #5 NLC_Clk = ~NLC_Clk;

    nested_loop_counter #(.BITWIDTH(BW), .LEVELS(LV), .NEG_EDGE(1)) dut (
        .NLC_Clk      (NLC_Clk),
        .NLC_Rst      (NLC_Rst),
        .NLC_Clr      (NLC_Clr),
        .NLC_Start    (NLC_Start),
        .NLC_En       (NLC_En),
        .NLC_Limit    (NLC_Limit),
`ifdef NLC_STRIDE_EN
        .NLC_Stride   (NLC_Stride),
`endif
        .NLC_Out      (NLC_Out),
        .NLC_Eqn_Flag (NLC_Eqn_Flag),
        .NLC_Wrap     (NLC_Wrap),
        .NLC_Busy     (NLC_Busy),
        .NLC_Done     (NLC_Done)
    );

    typedef struct packed {
        logic [LV*BW-1:0] out;
        logic [LV-1:0]    eqn;
        logic [LV-1:0]    wrap;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    int mi[LV], ml[LV], ms[LV];
    int mst;
    bit mdone;

    function automatic int step_of(input int s);
        return (s == 0) ? 1 : s;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < LV; k++) begin
            mi[k] = 0; ml[k] = 0; ms[k] = 0;
        end
        mst = 0;
        mdone = 1'b0;
    endfunction

    function automatic void model_step(input bit clr, input bit start, input bit en);
        bit carry;
        mdone = 1'b0;
        if (clr) begin
            mst = 0;
            for (int k = 0; k < LV; k++) mi[k] = 0;
        end else if (mst == 0) begin
            if (start) begin
                for (int k = 0; k < LV; k++) begin
                    mi[k] = 0;
                    ml[k] = int'(NLC_Limit[k*BW +: BW]);
`ifdef NLC_STRIDE_EN
                    ms[k] = int'(NLC_Stride[k*BW +: BW]);
`else
                    ms[k] = 1;
`endif
                end
                mst = 1;
            end
        end else if (mst == 1) begin
            if (en) begin
                carry = 1'b1;
                for (int k = 0; k < LV; k++) begin
                    if (carry) begin
                        if (mi[k] + step_of(ms[k]) > ml[k]) begin
                            mi[k] = 0;
                        end else begin
                            mi[k] = mi[k] + step_of(ms[k]);
                            carry = 1'b0;
                        end
                    end
                end
                if (carry) begin
                    mdone = 1'b1;
                    mst = 2;
                end
            end
        end else begin
            mst = 0;
        end
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        bit   pre;
        e = '0;
        pre = 1'b1;
        for (int k = 0; k < LV; k++) begin
            e.out[k*BW +: BW] = mi[k][BW-1:0];
            if (mst != 0) begin
                e.eqn[k] = (mi[k] == ml[k]);
                pre = pre & (mi[k] + step_of(ms[k]) > ml[k]);
                e.wrap[k] = pre;
            end
        end
        e.busy = (mst == 1);
        e.done = mdone;
        return e;
    endfunction

    task automatic check_head(input string tag);
        exp_t e;
        e = sbq.pop_front();
        vectors++;
        assert (NLC_Out === e.out) else begin
            miscompares++;
            $error("FAIL %s out: observed %h expected %h", tag, NLC_Out, e.out);
        end
        vectors++;
        assert (NLC_Busy === e.busy) else begin
            miscompares++;
            $error("FAIL %s busy: observed %b expected %b", tag, NLC_Busy, e.busy);
        end
        vectors++;
        assert (NLC_Done === e.done) else begin
            miscompares++;
            $error("FAIL %s done: observed %b expected %b", tag, NLC_Done, e.done);
        end
        vectors++;
        assert (NLC_Eqn_Flag === e.eqn) else begin
            miscompares++;
            $error("FAIL %s eqn: observed %b expected %b", tag, NLC_Eqn_Flag, e.eqn);
        end
        vectors++;
        assert (NLC_Wrap === e.wrap) else begin
            miscompares++;
            $error("FAIL %s wrap: observed %b expected %b", tag, NLC_Wrap, e.wrap);
        end
    endtask

    task automatic cycle(input bit clr, input bit start, input bit en, input string tag);
        NLC_Clr   = clr;
        NLC_Start = start;
        NLC_En    = en;
        model_step(clr, start, en);
        sbq.push_back(model_exp());
        @(negedge NLC_Clk);
        #1;
        check_head(tag);
        NLC_Clr = 1'b0; NLC_Start = 1'b0; NLC_En = 1'b0;
    endtask

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [LV*BW-1:0] pack3(input int l2, input int l1, input int l0);
        logic [BW-1:0] a, b, c;
        a = l2[BW-1:0]; b = l1[BW-1:0]; c = l0[BW-1:0];
        return {a, b, c};
    endfunction

    int n_en;
    bit seen;

    initial begin
        NLC_Rst = 1'b1; NLC_Clr = 1'b0; NLC_Start = 1'b0; NLC_En = 1'b0;
        NLC_Limit = pack3(1, 2, 3);
`ifdef NLC_STRIDE_EN
        NLC_Stride = '0;
`endif
        model_reset();
        #1;
        sbq.push_back(model_exp());
        check_head("reset");
        #2 NLC_Rst = 1'b0;

        // 1: continuous scan, Done on the 24th En
        NLC_Limit = pack3(1, 2, 3);
        cycle(0, 1, 0, "t1_start");
        n_en = 0; seen = 1'b0;
        while (!seen && n_en < 40) begin
            cycle(0, 0, 1, "t1_run");
            n_en++;
            if (NLC_Done) seen = 1'b1;
        end
        check_val("t1_done_edge", 64'(n_en), 64'd24);
        cycle(0, 0, 0, "t1_after");
        check_val("t1_busy_low", 64'(NLC_Busy), 64'd0);

        // 2: five En pulses with gaps
        cycle(0, 1, 0, "t2_start");
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, "t2_en");
            cycle(0, 0, 0, "t2_gap");
        end
        check_val("t2_out", 64'(NLC_Out), 64'(pack3(0, 1, 1)));
        check_val("t2_wrap0", 64'(NLC_Wrap[0]), 64'd0);
        cycle(1, 0, 0, "t2_clr");

        // 3: asynchronous reset mid-scan
        cycle(0, 1, 0, "t3_start");
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, "t3_en");
        #2 NLC_Rst = 1'b1;
        #1;
        check_val("t3_rst_out", 64'(NLC_Out), 64'd0);
        check_val("t3_rst_busy", 64'(NLC_Busy), 64'd0);
        check_val("t3_rst_done", 64'(NLC_Done), 64'd0);
        model_reset();
        @(posedge NLC_Clk);
        NLC_Rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, "t3_post");

        // 4: all limits zero
        NLC_Limit = '0;
        cycle(0, 1, 0, "t4_start");
        check_val("t4_eqn", 64'(NLC_Eqn_Flag), 64'h7);
        cycle(0, 0, 1, "t4_en");
        check_val("t4_done", 64'(NLC_Done), 64'd1);
        cycle(0, 0, 0, "t4_idle");

        // 5: Clr beats Start
        NLC_Limit = pack3(1, 2, 3);
        cycle(1, 1, 0, "t5_clrstart");
        cycle(0, 0, 1, "t5_en");
        check_val("t5_busy", 64'(NLC_Busy), 64'd0);
        check_val("t5_out", 64'(NLC_Out), 64'd0);

`ifdef NLC_STRIDE_EN
        // 6: stride 4 on level 0
        NLC_Limit  = pack3(0, 1, 9);
        NLC_Stride = pack3(0, 0, 4);
        cycle(0, 1, 0, "t6_start");
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 1, "t6_en");
            check_val("t6_l0", 64'(NLC_Out[BW-1:0]), 64'(((i + 1) % 3) * 4));
        end
        check_val("t6_done", 64'(NLC_Done), 64'd1);
        cycle(0, 0, 0, "t6_idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
